// File: rtl/pe_mac_param.sv
// Signed multiply-accumulate PE with shift-in filter/ifmap scratchpads and a valid/ready result port.
// Define PE_MAC_SATURATE_EN to clamp products and sums instead of wrapping.
module pe_mac_param #(
    parameter int DATA_W     = 8,
    parameter int PSUM_W     = 10,
    parameter int TAPS       = 3,
    parameter int FRAC_SHIFT = 6
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic signed [DATA_W-1:0] filter_i,
    input  logic                     filter_load_i,
    input  logic signed [DATA_W-1:0] ifmap_i,
    input  logic                     ifmap_load_i,
    input  logic                     start_i,
    input  logic signed [PSUM_W-1:0] psum_i,
    output logic signed [PSUM_W-1:0] psum_o,
    output logic                     psum_valid_o,
    input  logic                     psum_ready_i,
    output logic                     busy_o
);

    // state | meaning
    // IDLE  | waiting for start_i, scratchpads loadable
    // MAC   | one tap per cycle into the accumulator
    // ACC   | add upstream psum_i, register result
    // HOLD  | result presented until psum_ready_i
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;

`ifdef PE_MAC_SATURATE_EN
    localparam logic signed [PSUM_W-1:0] SAT_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic signed [PSUM_W-1:0] SAT_MIN = {1'b1, {(PSUM_W-1){1'b0}}};
`endif

    logic [1:0]               state;
    logic [CNT_W-1:0]         cnt;
    logic signed [DATA_W-1:0] filt_q [TAPS];
    logic signed [DATA_W-1:0] ifm_q  [TAPS];
    logic signed [PSUM_W-1:0] acc_q;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [PSUM_W-1:0] acc_next;
    logic signed [PSUM_W-1:0] out_sum;
    logic                     load_ok;

    function automatic logic signed [PSUM_W-1:0] reduce_prod(input logic signed [2*DATA_W-1:0] p);
`ifdef PE_MAC_SATURATE_EN
        logic signed [2*DATA_W-1:0] sh;
        sh = p >>> FRAC_SHIFT;
        if (sh > SAT_MAX)
            return SAT_MAX;
        else if (sh < SAT_MIN)
            return SAT_MIN;
        else
            return PSUM_W'(sh);
`else
        return PSUM_W'(p >>> FRAC_SHIFT);
`endif
    endfunction

    function automatic logic signed [PSUM_W-1:0] add_psum(input logic signed [PSUM_W-1:0] a,
                                                          input logic signed [PSUM_W-1:0] b);
`ifdef PE_MAC_SATURATE_EN
        logic signed [PSUM_W:0] s;
        s = a + b;
        if (s > SAT_MAX)
            return SAT_MAX;
        else if (s < SAT_MIN)
            return SAT_MIN;
        else
            return s[PSUM_W-1:0];
`else
        return a + b;
`endif
    endfunction

    assign load_ok  = (state == S_IDLE) || (state == S_HOLD);
    assign busy_o   = (state != S_IDLE);
    assign prod     = filt_q[cnt] * ifm_q[cnt];
    assign acc_next = add_psum(acc_q, reduce_prod(prod));
    assign out_sum  = add_psum(acc_q, psum_i);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= S_IDLE;
            cnt          <= '0;
            acc_q        <= '0;
            psum_o       <= '0;
            psum_valid_o <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                filt_q[i] <= '0;
                ifm_q[i]  <= '0;
            end
        end else begin
            // Oldest sample drifts toward entry 0.
            if (load_ok && filter_load_i) begin
                for (int i = 0; i < TAPS-1; i++)
                    filt_q[i] <= filt_q[i+1];
                filt_q[TAPS-1] <= filter_i;
            end
            if (load_ok && ifmap_load_i) begin
                for (int i = 0; i < TAPS-1; i++)
                    ifm_q[i] <= ifm_q[i+1];
                ifm_q[TAPS-1] <= ifmap_i;
            end

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state <= S_MAC;
                        cnt   <= '0;
                        acc_q <= '0;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_next;
                    if (cnt == CNT_W'(TAPS-1))
                        state <= S_ACC;
                    else
                        cnt <= cnt + CNT_W'(1);
                end
                S_ACC: begin
                    psum_o       <= out_sum;
                    psum_valid_o <= 1'b1;
                    state        <= S_HOLD;
                end
                S_HOLD: begin
                    if (psum_ready_i) begin
                        psum_valid_o <= 1'b0;
                        if (start_i) begin
                            state <= S_MAC;
                            cnt   <= '0;
                            acc_q <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_mac_param.sv
// Scoreboard bench for pe_mac_param: stimulus pushes model results, a negedge monitor pops on handshake.
module tb_pe_mac_param;

    localparam int DATA_W     = 8;
    localparam int PSUM_W     = 10;
    localparam int TAPS       = 3;
    localparam int FRAC_SHIFT = 6;

    logic                     clk_i = 1'b0;
    logic                     rstn_i = 1'b0;
    logic signed [DATA_W-1:0] filter_i = '0;
    logic                     filter_load_i = 1'b0;
    logic signed [DATA_W-1:0] ifmap_i = '0;
    logic                     ifmap_load_i = 1'b0;
    logic                     start_i = 1'b0;
    logic signed [PSUM_W-1:0] psum_i = '0;
    logic signed [PSUM_W-1:0] psum_o;
    logic                     psum_valid_o;
    logic                     psum_ready_i = 1'b0;
    logic                     busy_o;

    pe_mac_param #(
        .DATA_W(DATA_W), .PSUM_W(PSUM_W), .TAPS(TAPS), .FRAC_SHIFT(FRAC_SHIFT)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .filter_i(filter_i), .filter_load_i(filter_load_i),
        .ifmap_i(ifmap_i), .ifmap_load_i(ifmap_load_i),
        .start_i(start_i), .psum_i(psum_i),
        .psum_o(psum_o), .psum_valid_o(psum_valid_o),
        .psum_ready_i(psum_ready_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_q[$];
    int mf[TAPS];
    int mi[TAPS];

    task automatic check(input string name, input int got, input int exp);
        total_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Reference arithmetic: floor-scaled products, then either clamp or two's-complement wrap.
    function automatic int fit(input int x);
        int hi;
        int lo;
        int m;
        int r;
        hi = (1 << (PSUM_W-1)) - 1;
        lo = -(1 << (PSUM_W-1));
        m  = 1 << PSUM_W;
`ifdef PE_MAC_SATURATE_EN
        r = (x > hi) ? hi : ((x < lo) ? lo : x);
`else
        r = x % m;
        if (r < 0) r += m;
        if (r > hi) r -= m;
`endif
        return r;
    endfunction

    function automatic int model(input int psum);
        int acc;
        acc = 0;
        for (int c = 0; c < TAPS; c++)
            acc = fit(acc + fit((mf[c] * mi[c]) >>> FRAC_SHIFT));
        return fit(acc + psum);
    endfunction

    function automatic int rnd_data();
        return int'($urandom_range(0, (1 << DATA_W) - 1)) - (1 << (DATA_W-1));
    endfunction

    always @(negedge clk_i) begin
        if (rstn_i && psum_valid_o && psum_ready_i) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL sb_unexpected: got %0d, expected no output", int'(psum_o));
            end else begin
                check("sb_psum", int'(psum_o), exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load(input int f, input int m, input bit lf, input bit lm);
        filter_i      = DATA_W'(f);
        ifmap_i       = DATA_W'(m);
        filter_load_i = lf;
        ifmap_load_i  = lm;
        tick();
        filter_load_i = 1'b0;
        ifmap_load_i  = 1'b0;
        if (lf) begin
            for (int i = 0; i < TAPS-1; i++) mf[i] = mf[i+1];
            mf[TAPS-1] = f;
        end
        if (lm) begin
            for (int i = 0; i < TAPS-1; i++) mi[i] = mi[i+1];
            mi[TAPS-1] = m;
        end
    endtask

    task automatic wait_valid(input string name, output int lat);
        lat = 0;
        while (!psum_valid_o && lat < 20) begin
            tick();
            lat++;
        end
        if (!psum_valid_o) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic run_conv(input string name, input int psum, input int stall, input bit poke,
                            output int lat);
        logic signed [PSUM_W-1:0] hold;
        exp_q.push_back(model(psum));
        psum_i       = PSUM_W'(psum);
        psum_ready_i = (stall == 0);
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        check({name, "_busy_mac"}, int'(busy_o), 1);
        if (poke) begin
            ifmap_i      = DATA_W'(99);
            ifmap_load_i = 1'b1;
            tick();
            ifmap_load_i = 1'b0;
            wait_valid(name, lat);
            lat++;
        end else begin
            wait_valid(name, lat);
        end
        if (stall > 0) begin
            hold = psum_o;
            for (int s = 0; s < stall; s++) begin
                tick();
                check({name, "_stall_valid"}, int'(psum_valid_o), 1);
                check({name, "_stall_psum"}, int'(psum_o), int'(hold));
            end
            psum_ready_i = 1'b1;
        end
        tick();
        check({name, "_valid_drop"}, int'(psum_valid_o), 0);
        check({name, "_idle"}, int'(busy_o), 0);
    endtask

    initial begin
        int lat;
        logic signed [PSUM_W-1:0] hold;
        for (int i = 0; i < TAPS; i++) begin mf[i] = 0; mi[i] = 0; end

        #12;
        check("rst_psum", int'(psum_o), 0);
        check("rst_valid", int'(psum_valid_o), 0);
        check("rst_busy", int'(busy_o), 0);
        rstn_i = 1'b1;
        tick();

        // Basic: 64*{1,2,3} scaled by 1/64 plus 10.
        load(64, 1, 1, 1); load(64, 2, 1, 1); load(64, 3, 1, 1);
        run_conv("basic", 10, 0, 0, lat);
        check("basic_latency", lat, TAPS + 1);

        load(-64, 1, 1, 1); load(0, 0, 1, 1); load(0, 0, 1, 1);
        run_conv("neg", 0, 0, 0, lat);

        for (int i = 0; i < TAPS; i++) load(127, 127, 1, 1);
        run_conv("ovf", 0, 0, 0, lat);

        // Back-pressure with a lone start and an accepted filter load during HOLD.
        load(40, 5, 1, 1); load(-30, 9, 1, 1); load(20, -7, 1, 1);
        exp_q.push_back(model(7));
        psum_i       = PSUM_W'(7);
        psum_ready_i = 1'b0;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        wait_valid("bp", lat);
        check("bp_latency", lat, TAPS + 1);
        hold = psum_o;
        for (int s = 0; s < 5; s++) begin
            if (s == 1) start_i = 1'b1;
            if (s == 2) begin filter_i = DATA_W'(32); filter_load_i = 1'b1; end
            tick();
            start_i       = 1'b0;
            filter_load_i = 1'b0;
            if (s == 2) begin
                for (int i = 0; i < TAPS-1; i++) mf[i] = mf[i+1];
                mf[TAPS-1] = 32;
            end
            check("bp_stall_valid", int'(psum_valid_o), 1);
            check("bp_stall_psum", int'(psum_o), int'(hold));
        end
        exp_q.push_back(model(7));
        psum_ready_i = 1'b1;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        check("bp_b2b_busy", int'(busy_o), 1);
        check("bp_b2b_valid", int'(psum_valid_o), 0);
        wait_valid("bp2", lat);
        check("bp_b2b_latency", lat, TAPS + 1);
        tick();
        check("bp2_valid_drop", int'(psum_valid_o), 0);

        // Reset during the second MAC cycle discards the convolution.
        load(50, 50, 1, 1);
        exp_q.push_back(model(3));
        psum_i  = PSUM_W'(3);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        rstn_i = 1'b0;
        #1;
        exp_q.delete();
        for (int i = 0; i < TAPS; i++) begin mf[i] = 0; mi[i] = 0; end
        check("midrst_psum", int'(psum_o), 0);
        check("midrst_valid", int'(psum_valid_o), 0);
        check("midrst_busy", int'(busy_o), 0);
        rstn_i = 1'b1;
        tick();
        run_conv("post_rst", 5, 0, 0, lat);

        // ifmap load during MAC is ignored; the repeat run proves the scratchpad is untouched.
        load(11, -20, 1, 1); load(-90, 33, 1, 1); load(77, 64, 1, 1);
        run_conv("poke", -4, 0, 1, lat);
        check("poke_latency", lat, TAPS + 1);
        run_conv("poke_rerun", 12, 0, 0, lat);

        for (int n = 0; n < 15; n++) begin
            for (int t = 0; t < TAPS; t++)
                load(rnd_data(), rnd_data(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
            run_conv("rand", int'($urandom_range(0, (1 << PSUM_W) - 1)) - (1 << (PSUM_W-1)),
                     int'($urandom_range(0, 3)), 1'b0, lat);
        end

        tick();
        check("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
